// File: rtl/ysyx_22050368_alu_pkg.sv
// rtl/ysyx_22050368_alu_pkg.sv - shared ALU widths, mode codes and response record
// Optional flag fields follow YSYX_22050368_ALU_ARB_FLAGS_EN.
package ysyx_22050368_alu_pkg;
  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  result;
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
    logic             zero;
    logic             of;
`endif
  } alu_rsp_t;
endpackage

// File: rtl/ysyx_22050368_alu_arb_if.sv
// rtl/ysyx_22050368_alu_arb_if.sv - requester, ALU and response bundle of the ALU arbiter
// rsp_zero/rsp_of exist only with YSYX_22050368_ALU_ARB_FLAGS_EN.
interface ysyx_22050368_alu_arb_if #(
  parameter int XLEN  = ysyx_22050368_alu_pkg::XLEN,
  parameter int TAG_W = ysyx_22050368_alu_pkg::TAG_W
);
  logic             req0_valid, req0_ready;
  logic [XLEN-1:0]  req0_op1, req0_op2;
  logic [2:0]       req0_mode;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [XLEN-1:0]  req1_op1, req1_op2;
  logic [2:0]       req1_mode;
  logic [TAG_W-1:0] req1_tag;
  logic             alu_en;
  logic [XLEN-1:0]  alu_op1, alu_op2;
  logic [2:0]       alu_mode;
  logic [XLEN-1:0]  alu_result;
  logic             alu_zero, alu_of;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_result;
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
  logic             rsp_zero, rsp_of;
`endif

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_mode, req0_tag,
    input  req1_valid, req1_op1, req1_op2, req1_mode, req1_tag,
    input  alu_result, alu_zero, alu_of, rsp_ready,
    output req0_ready, req1_ready, alu_en, alu_op1, alu_op2, alu_mode,
    output rsp_valid, rsp_id, rsp_tag, rsp_result
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
    , output rsp_zero, rsp_of
`endif
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_mode, req0_tag,
    output req1_valid, req1_op1, req1_op2, req1_mode, req1_tag,
    output alu_result, alu_zero, alu_of, rsp_ready,
    input  req0_ready, req1_ready, alu_en, alu_op1, alu_op2, alu_mode,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
    , input rsp_zero, rsp_of
`endif
  );
endinterface

// File: rtl/ysyx_22050368_rr_arb2.sv
// rtl/ysyx_22050368_rr_arb2.sv - two-way round-robin arbiter owning the priority pointer
module ysyx_22050368_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic r_prio;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Only a completed transfer moves the pointer, so a stalled winner keeps priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_prio <= 1'b0;
    else if (advance)
      r_prio <= gnt[0];
  end
endmodule

// File: rtl/ysyx_22050368_alu_arb.sv
// rtl/ysyx_22050368_alu_arb.sv - shares one combinational ALU between two requesters
// Flag capture is built only with YSYX_22050368_ALU_ARB_FLAGS_EN.
module ysyx_22050368_alu_arb #(
  parameter int XLEN  = ysyx_22050368_alu_pkg::XLEN,
  parameter int TAG_W = ysyx_22050368_alu_pkg::TAG_W
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22050368_alu_arb_if.slave bus
);
  import ysyx_22050368_alu_pkg::*;

  logic [1:0]       w_req, w_gnt;
  logic             w_slot_free, w_fire, w_sel1;
  logic [TAG_W-1:0] w_tag;
  logic             r_rsp_valid;
  alu_rsp_t         r_rsp, w_rsp_next;

  assign w_req       = {bus.req1_valid, bus.req0_valid};
  assign w_slot_free = ~r_rsp_valid | bus.rsp_ready;
  assign bus.req0_ready = w_gnt[0] & w_slot_free & ~rst;
  assign bus.req1_ready = w_gnt[1] & w_slot_free & ~rst;
  assign w_fire = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
  assign w_sel1 = w_gnt[1];

  ysyx_22050368_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_fire),
    .gnt     (w_gnt)
  );

  assign bus.alu_en   = w_fire;
  assign bus.alu_op1  = w_fire ? (w_sel1 ? bus.req1_op1 : bus.req0_op1) : {XLEN{1'b0}};
  assign bus.alu_op2  = w_fire ? (w_sel1 ? bus.req1_op2 : bus.req0_op2) : {XLEN{1'b0}};
  assign bus.alu_mode = w_fire ? (w_sel1 ? bus.req1_mode : bus.req0_mode) : 3'b000;
  assign w_tag        = w_sel1 ? bus.req1_tag : bus.req0_tag;

  always_comb begin
    w_rsp_next        = '0;
    w_rsp_next.id     = w_sel1;
    w_rsp_next.tag    = w_tag;
    w_rsp_next.result = bus.alu_result;
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
    w_rsp_next.zero   = bus.alu_zero;
    w_rsp_next.of     = bus.alu_of;
`endif
  end

  // A reload on the consuming cycle keeps rsp_valid high for back-to-back issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp       <= w_rsp_next;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp.id;
  assign bus.rsp_tag    = r_rsp.tag;
  assign bus.rsp_result = r_rsp.result;
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
  assign bus.rsp_zero   = r_rsp.zero;
  assign bus.rsp_of     = r_rsp.of;
`else
  logic w_unused_flags;
  assign w_unused_flags = bus.alu_zero ^ bus.alu_of;
`endif

  a_req0_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.req0_valid && !bus.req0_ready) |=> (!bus.req0_valid ||
      ($stable(bus.req0_op1) && $stable(bus.req0_op2) && $stable(bus.req0_mode) && $stable(bus.req0_tag))));
  a_req1_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.req1_valid && !bus.req1_ready) |=> (!bus.req1_valid ||
      ($stable(bus.req1_op1) && $stable(bus.req1_op2) && $stable(bus.req1_mode) && $stable(bus.req1_tag))));
endmodule

// File: tb/tb_ysyx_22050368_alu_arb.sv
// tb/tb_ysyx_22050368_alu_arb.sv - self-checking bench for the two-port ALU arbiter
module tb_ysyx_22050368_alu_arb;
  import ysyx_22050368_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050368_alu_arb_if #(.XLEN(64), .TAG_W(4)) bus();
  ysyx_22050368_alu_arb #(.XLEN(64), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [63:0] r; logic z; logic o; } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b);
    alu_out_t o;
    o = '0;
    case (m)
      ALU_ADD: begin o.r = a + b; o.o = (a[63] == b[63]) && (o.r[63] != a[63]); o.z = (o.r == 64'd0); end
      ALU_SUB: begin o.r = a - b; o.o = (a[63] != b[63]) && (o.r[63] != a[63]); o.z = (o.r == 64'd0); end
      ALU_NOT: o.r = ~a;
      ALU_AND: o.r = a & b;
      ALU_OR:  o.r = a | b;
      ALU_XOR: o.r = a ^ b;
      ALU_SLT: o.r = {63'd0, $signed(a) < $signed(b)};
      default: o.r = {63'd0, a == b};
    endcase
    return o;
  endfunction

  // Stand-in for the shared ALU that sits beside the arbiter.
  alu_out_t alu_w;
  always_comb begin
    alu_w          = alu_ref(bus.alu_mode, bus.alu_op1, bus.alu_op2);
    bus.alu_result = alu_w.r;
    bus.alu_zero   = alu_w.z;
    bus.alu_of     = alu_w.o;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [2:0] m,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] t);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_mode = m; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_mode = m; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_tag = t;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    int          p;
    logic [2:0]  m;
    logic [63:0] a, b;
    logic [3:0]  t;
    logic [63:0] r;
    logic        z, o;
  } vec_t;

  typedef struct { logic id; logic [3:0] tag; logic [63:0] r; logic z, o; } exp_t;

  vec_t        vt[12];
  exp_t        q[$];
  exp_t        e;
  alu_out_t    ao;
  int          m_prio, g;
  logic        rr, slot;
  logic        v[2];
  logic [2:0]  md[2];
  logic [63:0] oa[2], ob[2];
  logic [3:0]  tg[2];
  bit          pend[2];

  initial begin
    vt[0]  = '{0, ALU_ADD, 64'd5, 64'd7, 4'h1, 64'd12, 1'b0, 1'b0};
    vt[1]  = '{1, ALU_SUB, 64'd9, 64'd9, 4'h2, 64'd0, 1'b1, 1'b0};
    vt[2]  = '{0, ALU_NOT, 64'h0, 64'h5, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[3]  = '{1, ALU_AND, 64'hF0F0, 64'hFF00, 4'h4, 64'hF000, 1'b0, 1'b0};
    vt[4]  = '{0, ALU_OR,  64'h0F0F, 64'hF000, 4'h5, 64'hFF0F, 1'b0, 1'b0};
    vt[5]  = '{1, ALU_XOR, 64'hAAAA, 64'hFFFF, 4'h6, 64'h5555, 1'b0, 1'b0};
    vt[6]  = '{0, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h7, 64'd1, 1'b0, 1'b0};
    vt[7]  = '{1, ALU_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h8, 64'd0, 1'b0, 1'b0};
    vt[8]  = '{0, ALU_EQ,  64'd7, 64'd7, 4'h9, 64'd1, 1'b0, 1'b0};
    vt[9]  = '{1, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 4'hA, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vt[10] = '{0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'hB, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[11] = '{1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hC, 64'd0, 1'b1, 1'b0};

    // Reset state, with a request already pending while rst is high.
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    set_req(0, 1'b1, ALU_ADD, 64'd5, 64'd7, 4'd3);
    bus.rsp_ready = 1'b1;
    #3;
    chk("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    chk("rst_alu_en", {63'd0, bus.alu_en}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_result", bus.rsp_result, 64'd0);
    chk("rst_rsp_tag", {60'd0, bus.rsp_tag}, 64'd0);
    chk("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    step();
    rst = 1'b0;
    #2;
    chk("single_ready0", {63'd0, bus.req0_ready}, 64'd1);
    chk("single_alu_en", {63'd0, bus.alu_en}, 64'd1);
    chk("single_alu_op1", bus.alu_op1, 64'd5);
    chk("single_alu_op2", bus.alu_op2, 64'd7);
    chk("single_alu_mode", {61'd0, bus.alu_mode}, 64'd0);
    step();
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    chk("single_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("single_rsp_result", bus.rsp_result, 64'd12);
    chk("single_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    chk("single_rsp_tag", {60'd0, bus.rsp_tag}, 64'd3);
    #2;
    chk("single_alu_en_pulse", {63'd0, bus.alu_en}, 64'd0);
    chk("idle_alu_op1", bus.alu_op1, 64'd0);
    step();
    chk("single_drain", {63'd0, bus.rsp_valid}, 64'd0);

    // One operation per mode, alternating ports.
    for (int i = 0; i < 12; i++) begin
      set_req(vt[i].p, 1'b1, vt[i].m, vt[i].a, vt[i].b, vt[i].t);
      #2;
      chk("tbl_alu_en", {63'd0, bus.alu_en}, 64'd1);
      step();
      set_req(vt[i].p, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
      chk("tbl_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("tbl_rsp_result", bus.rsp_result, vt[i].r);
      chk("tbl_rsp_id", {63'd0, bus.rsp_id}, 64'(vt[i].p));
      chk("tbl_rsp_tag", {60'd0, bus.rsp_tag}, {60'd0, vt[i].t});
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
      chk("tbl_rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, vt[i].z});
      chk("tbl_rsp_of", {63'd0, bus.rsp_of}, {63'd0, vt[i].o});
`endif
      step();
      chk("tbl_drain", {63'd0, bus.rsp_valid}, 64'd0);
    end

    // Contention: grants alternate starting with req0.
    do_reset();
    set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd1, 4'd1);
    set_req(1, 1'b1, ALU_ADD, 64'd2, 64'd2, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("cont_ready0", {63'd0, bus.req0_ready}, 64'(i % 2 == 0));
      chk("cont_ready1", {63'd0, bus.req1_ready}, 64'(i % 2 == 1));
      step();
      chk("cont_rsp_id", {63'd0, bus.rsp_id}, 64'(i % 2));
      chk("cont_rsp_result", bus.rsp_result, (i % 2 == 1) ? 64'd4 : 64'd2);
    end

    // Backpressure: everything freezes, then prio (req0) resumes.
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #2;
      chk("bp_ready0", {63'd0, bus.req0_ready}, 64'd0);
      chk("bp_ready1", {63'd0, bus.req1_ready}, 64'd0);
      chk("bp_alu_en", {63'd0, bus.alu_en}, 64'd0);
      step();
      chk("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("bp_rsp_id", {63'd0, bus.rsp_id}, 64'd1);
      chk("bp_rsp_result", bus.rsp_result, 64'd4);
    end
    bus.rsp_ready = 1'b1;
    #2;
    chk("bp_rel_ready0", {63'd0, bus.req0_ready}, 64'd1);
    chk("bp_rel_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    chk("bp_rel_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    chk("bp_rel_rsp_tag", {60'd0, bus.rsp_tag}, 64'd1);
    chk("bp_rel_rsp_result", bus.rsp_result, 64'd2);
    step();
    chk("bp_drain", {63'd0, bus.rsp_valid}, 64'd0);

    // Back-to-back xor ops from req0.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, ALU_XOR, 64'h11 * (i + 1), 64'hF0F0, 4'(i));
      #2;
      chk("b2b_ready0", {63'd0, bus.req0_ready}, 64'd1);
      step();
      chk("b2b_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      chk("b2b_rsp_result", bus.rsp_result, (64'h11 * (i + 1)) ^ 64'hF0F0);
      chk("b2b_rsp_tag", {60'd0, bus.rsp_tag}, 64'(i));
    end
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    step();
    chk("b2b_drain", {63'd0, bus.rsp_valid}, 64'd0);

    // Reset while a response is held unconsumed.
    set_req(0, 1'b1, ALU_ADD, 64'd3, 64'd4, 4'd5);
    bus.rsp_ready = 1'b0;
    step();
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    chk("mid_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("mid_rsp_result", bus.rsp_result, 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("mid_async_result", bus.rsp_result, 64'd0);
    chk("mid_async_tag", {60'd0, bus.rsp_tag}, 64'd0);
    step();
    rst = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 64'd1, 64'd1, 4'd1);
    set_req(1, 1'b1, ALU_ADD, 64'd2, 64'd2, 4'd2);
    bus.rsp_ready = 1'b1;
    #2;
    chk("mid_post_ready0", {63'd0, bus.req0_ready}, 64'd1);
    chk("mid_post_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    set_req(0, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    chk("mid_post_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    step();

    // Random traffic against a queue-based reference.
    do_reset();
    m_prio = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          v[p]  = 1'($urandom_range(0, 1));
          md[p] = 3'($urandom_range(0, 7));
          oa[p] = {$urandom, $urandom};
          ob[p] = ($urandom_range(0, 3) == 0) ? oa[p] : {$urandom, $urandom};
          tg[p] = 4'($urandom);
        end
        set_req(p, v[p], md[p], oa[p], ob[p], tg[p]);
      end
      rr = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = rr;
      #2;
      slot = (q.size() == 0) || rr;
      g = -1;
      if (v[0] && v[1]) g = m_prio;
      else if (v[0]) g = 0;
      else if (v[1]) g = 1;
      if (!slot) g = -1;
      chk("rnd_ready0", {63'd0, bus.req0_ready}, 64'(g == 0));
      chk("rnd_ready1", {63'd0, bus.req1_ready}, 64'(g == 1));
      chk("rnd_alu_en", {63'd0, bus.alu_en}, 64'(g >= 0));
      if (g >= 0) begin
        chk("rnd_alu_op1", bus.alu_op1, oa[g]);
        chk("rnd_alu_op2", bus.alu_op2, ob[g]);
        chk("rnd_alu_mode", {61'd0, bus.alu_mode}, {61'd0, md[g]});
      end else begin
        chk("rnd_alu_idle", bus.alu_op1 | bus.alu_op2 | {61'd0, bus.alu_mode}, 64'd0);
      end
      chk("rnd_rsp_valid", {63'd0, bus.rsp_valid}, 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_rsp_result", bus.rsp_result, q[0].r);
        chk("rnd_rsp_id", {63'd0, bus.rsp_id}, {63'd0, q[0].id});
        chk("rnd_rsp_tag", {60'd0, bus.rsp_tag}, {60'd0, q[0].tag});
`ifdef YSYX_22050368_ALU_ARB_FLAGS_EN
        chk("rnd_rsp_flags", {62'd0, bus.rsp_zero, bus.rsp_of}, {62'd0, q[0].z, q[0].o});
`endif
        if (rr) void'(q.pop_front());
      end
      if (g >= 0) begin
        ao = alu_ref(md[g], oa[g], ob[g]);
        e.id = (g == 1);
        e.tag = tg[g];
        e.r = ao.r;
        e.z = ao.z;
        e.o = ao.o;
        q.push_back(e);
        m_prio = (g == 0) ? 1 : 0;
      end
      for (int p = 0; p < 2; p++) pend[p] = v[p] && (g != p);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22050368_alu_arb.md
# ysyx_22050368_alu_arb

Two-port round-robin arbiter and sequencer that shares the single combinational ALU between two requesters, e.g. the EXU and the branch/address-generation path. It grants one request per cycle, drives the ALU port set, and captures the ALU result into a one-entry response register with valid/ready backpressure. The block sits directly in front of the shared ALU instance. The ALU itself is instantiated alongside this block, not inside it.

## Interface
Parameters:
- XLEN, 64, operand and result width.
- TAG_W, 4, opaque requester tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- reqN_valid  in  1  request N valid, N ∈ {0,1}.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_op1, reqN_op2  in  XLEN  operands.
- reqN_mode  in  3  ALU mode (0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 slt, 7 eq).
- reqN_tag  in  TAG_W  returned unchanged with the result.
- alu_en  out  1  ALU enable.
- alu_op1, alu_op2  out  XLEN  ALU operands.
- alu_mode  out  3  ALU mode.
- alu_result  in  XLEN  ALU result.
- alu_zero, alu_of  in  1  ALU zero and overflow flags.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_tag  out  TAG_W  tag of the owning request.
- rsp_result  out  XLEN  captured result.
- rsp_zero, rsp_of  out  1  captured flags; present only with the flags macro (see Configuration).

## Operation
- Slot free condition: `slot_free = ~rsp_valid | rsp_ready`.
- Grant rules:
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the requester selected by the priority pointer `prio`.
- Handshake:
  - `reqN_ready = grantN & slot_free & ~rst`.
  - At most one `reqN_ready` is high per cycle.
  - `reqN_ready` never depends on `reqN_valid` of the other port beyond the arbitration itself.
- ALU drive:
  - `alu_en = fire`, where `fire` means any `reqN_valid & reqN_ready`.
  - When `fire` is high, `alu_op1`, `alu_op2` and `alu_mode` carry the granted request's fields.
  - When `fire` is low, `alu_op1`, `alu_op2` and `alu_mode` are 0.
- Capture:
  - On `fire`, the response register loads `alu_result`, `rsp_id`, `rsp_tag` and the flags, and sets `rsp_valid`.
  - If `rsp_valid & rsp_ready` occurs without `fire`, `rsp_valid` clears.
  - If both occur in the same cycle, the register reloads and `rsp_valid` stays 1. This gives back-to-back throughput of one operation per cycle.
- Priority pointer:
  - After any grant to N, `prio` moves to the other requester.
  - With no grant, `prio` holds.
  - A requester held off by backpressure keeps its priority.
- Flags:
  - The zero and overflow flags are meaningful only for modes 0 and 1, because the ALU forces them to 0 for other modes.
  - The flags are passed through unaltered.
- Requesters must hold their request fields stable while `valid` is high and `ready` is low. This is checked by assertion, not corrected.

## Timing
- Reset values:
  - `rsp_valid` = 0.
  - `rsp_result`, `rsp_tag`, `rsp_id` and the flags = 0.
  - `prio` = 0, so req0 is favoured first.
  - `reqN_ready` = 0 and `alu_en` = 0 while `rst` is high.
- Latency: a request accepted at edge k has `rsp_valid` = 1 from edge k through the edge at which `rsp_ready` is sampled high.
- Throughput: 1 op/cycle while `rsp_ready` = 1.
- Stall: with `rsp_valid` = 1 and `rsp_ready` = 0, both readies are low, and the response and `prio` hold indefinitely.
- Reset mid-operation: a held, unconsumed response is discarded and `prio` returns to 0.
- Simultaneous valid on both ports with a free slot: exactly one grant, per `prio`.
- All outputs except `reqN_ready` and the `alu_*` signals are registered. `reqN_ready` and the `alu_*` signals are combinational from `reqN_valid`, `rsp_valid`, `rsp_ready` and `prio`.

## Configuration
- Macro: YSYX_22050368_ALU_ARB_FLAGS_EN.
- When the macro is defined:
  - The `rsp_zero` and `rsp_of` ports exist.
  - The flags are registered alongside the result.
- When the macro is not defined:
  - The `rsp_zero` and `rsp_of` ports are absent.
  - `alu_zero` and `alu_of` are ignored, and no flag flops are built.
  - All other behaviour is identical.

## Structure
- Shared package `ysyx_22050368_alu_pkg` holds:
  - `XLEN`.
  - The mode localparams `ALU_ADD` = 0 through `ALU_EQ` = 7.
  - The response struct typedef for id, tag, result and flags.
- Sub-module `ysyx_22050368_rr_arb2`:
  - Contains a 2-way round-robin arbiter with inputs `req[1:0]` and `advance`, and output `gnt[1:0]`.
  - Owns the `prio` flop, which advances only when `advance` is high.
- The top level handles the handshake, the ALU drive muxing and the response register.

## Test plan
- Reset then single request: after reset, req0 = {add, 5, 7, tag 3} with `rsp_ready` = 1 → `alu_en` pulses 1 cycle; next cycle `rsp_valid` = 1, result 12, id 0, tag 3.
- Contention: both valid every cycle with `rsp_ready` = 1 → grants alternate 0,1,0,1; the second grant goes to req1 after an initial req0 grant.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles with both requesting → both readies stay 0 and the response is stable. Release → the next grant follows the unchanged `prio`, with no lost or duplicated response.
- Back-to-back: req0 issues 4 xor ops with `rsp_ready` = 1 → 4 consecutive `rsp_valid` cycles with results in order.
- Flags (macro defined): sub with 0x8000…0 − 1 → `rsp_of` = ALU overflow value. Sub 9 − 9 → result 0, `rsp_zero` = 1. Mode 6 → `rsp_zero` = 0 regardless of result.
- Mid-operation reset: assert `rst` while `rsp_valid` = 1 and `rsp_ready` = 0 → `rsp_valid` drops to 0 asynchronously. After release, the first contended grant goes to req0.
